// File: rtl/dnmr_pkg.sv
// rtl/dnmr_pkg.sv - shared encodings and helpers for the N-modular redundancy voter
// Purpose: state and mode encodings plus the fault-counter width helper.
// Ports: none (package).
package dnmr_pkg;

  typedef enum logic [1:0] {
    ST_SIMPLEX = 2'd0,
    ST_NMR     = 2'd1,
    ST_DUPLEX  = 2'd2,
    ST_SAFE    = 2'd3
  } state_t;

  localparam logic [1:0] MODE_AUTO    = 2'd0;
  localparam logic [1:0] MODE_VOTE    = 2'd1;
  localparam logic [1:0] MODE_SIMPLEX = 2'd2;
  localparam logic [1:0] MODE_SLEEP   = 2'd3;

  // Bits needed to hold 0..max_count inclusive.
  function automatic int ctr_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/dnmr_fault_ctr.sv
// rtl/dnmr_fault_ctr.sv - per-replica saturating fault counter with retire strobe
// Purpose: counts disagreements up, agreements down, flags retirement.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         synchronous clear of the count
//   inc, dec    count up (saturating at MAX_COUNT) / down (floor 0)
//   retire      high when this increment makes the count reach MAX_COUNT
module dnmr_fault_ctr #(
  parameter int MAX_COUNT = 5,
  parameter int W         = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic retire
);

  logic [W-1:0] cnt;

  // Combinational so the fault bit can be set on the same edge the count lands on MAX.
  assign retire = inc && (cnt >= W'(MAX_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX_COUNT))) begin
      cnt <= cnt + 1'b1;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/dnmr_voter.sv
// rtl/dnmr_voter.sv - N-modular redundancy command voter with graceful degradation
// Purpose: majority-votes N replica commands, retires faulty replicas,
//          degrades NMR -> duplex -> safe default, and falls back to simplex
//          when the link error rate is low.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rep_cmd_i    N packed replica commands, replica k at [k*CMD_W +: CMD_W]
//   in_vld       rep_cmd_i valid strobe
//   err_rate     received-data error rate (drives vote hysteresis)
//   mode         0 auto, 1 force vote, 2 force simplex, 3 sleep
//   clr_fault    clears retirements, counters and the SAFE latch
//   cmd_o        selected command;  cmd_vld_o  one-cycle update strobe
//   fault        sticky retired mask; miscmp_o  per-vote disagreement pulse
//   state_o      0 SIMPLEX, 1 NMR, 2 DUPLEX, 3 SAFE
module dnmr_voter
  import dnmr_pkg::*;
#(
  parameter int N               = 3,
  parameter int CMD_W           = 4,
  parameter int DEF_CMD         = 5,
  parameter int MAX_FAULT_COUNT = 5,
  parameter int ERR_HI          = 8,
  parameter int ERR_LO          = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*CMD_W-1:0] rep_cmd_i,
  input  logic               in_vld,
  input  logic [3:0]         err_rate,
  input  logic [1:0]         mode,
  input  logic               clr_fault,
  output logic [CMD_W-1:0]   cmd_o,
  output logic               cmd_vld_o,
  output logic [N-1:0]       fault,
  output logic [N-1:0]       miscmp_o,
  output logic [1:0]         state_o
);

  localparam int               CW  = ctr_width(MAX_FAULT_COUNT);
  localparam logic [CMD_W-1:0] DEF = CMD_W'(DEF_CMD);
  localparam logic [3:0]       HI  = 4'(ERR_HI);
  localparam logic [3:0]       LO  = 4'(ERR_LO);

  logic [CMD_W-1:0] rep [N];
  logic [N-1:0]     act, inc, dec, retire, mis_nx;
  logic [CMD_W-1:0] cmd_nx;
  logic             vld_nx, vote_en, ve_nx, latch_q, latch_nx;
  state_t           state_q, st_nx;

  assign act     = ~fault;
  assign state_o = state_q;

  for (genvar k = 0; k < N; k++) begin : g_rep
    assign rep[k] = rep_cmd_i[k*CMD_W +: CMD_W];
    dnmr_fault_ctr #(.MAX_COUNT(MAX_FAULT_COUNT), .W(CW)) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr_fault),
      .inc    (inc[k]),
      .dec    (dec[k]),
      .retire (retire[k])
    );
  end

  always_comb begin
    int a;
    int m;
    logic got1, got2, found;
    logic [CMD_W-1:0] v1, v2, win;

    st_nx    = state_q;
    latch_nx = latch_q;
    cmd_nx   = cmd_o;
    vld_nx   = 1'b0;
    mis_nx   = '0;
    inc      = '0;
    dec      = '0;
    m        = 0;

    // Hysteresis: hold between LO and HI in auto/sleep modes.
    ve_nx = vote_en;
    case (mode)
      MODE_VOTE:    ve_nx = 1'b1;
      MODE_SIMPLEX: ve_nx = 1'b0;
      default: begin
        if (err_rate >= HI)     ve_nx = 1'b1;
        else if (err_rate < LO) ve_nx = 1'b0;
      end
    endcase

    a = $countones(act);

    // First two active replicas: simplex source and duplex pair.
    got1 = 1'b0;
    got2 = 1'b0;
    v1   = '0;
    v2   = '0;
    for (int i = 0; i < N; i++) begin
      if (act[i]) begin
        if (!got1) begin
          v1   = rep[i];
          got1 = 1'b1;
        end else if (!got2) begin
          v2   = rep[i];
          got2 = 1'b1;
        end
      end
    end

    // Pairwise majority among active replicas.
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      if (act[i]) begin
        m = 0;
        for (int j = 0; j < N; j++) begin
          if (act[j] && (rep[j] == rep[i])) m++;
        end
        if (!found && (m >= a / 2 + 1)) begin
          found = 1'b1;
          win   = rep[i];
        end
      end
    end

    if (clr_fault) begin
      // Clearing restores the full replica set; the coincident command is dropped.
      latch_nx = 1'b0;
      if (mode == MODE_SLEEP) begin
        st_nx  = ST_SAFE;
        cmd_nx = DEF;
      end else begin
        st_nx = ve_nx ? ST_NMR : ST_SIMPLEX;
      end
    end else if ((mode == MODE_SLEEP) || latch_q) begin
      st_nx  = ST_SAFE;
      cmd_nx = DEF;
    end else if (!ve_nx) begin
      if (a == 0) begin
        st_nx    = ST_SAFE;
        latch_nx = 1'b1;
        cmd_nx   = DEF;
      end else begin
        st_nx = ST_SIMPLEX;
        if (in_vld) begin
          cmd_nx = v1;
          vld_nx = 1'b1;
        end
      end
    end else if (a >= 3) begin
      st_nx = ST_NMR;
      if (in_vld) begin
        if (found) begin
          cmd_nx = win;
          vld_nx = 1'b1;
          for (int i = 0; i < N; i++) begin
            inc[i] = act[i] && (rep[i] != win);
            dec[i] = act[i] && (rep[i] == win);
          end
          mis_nx = inc;
        end else begin
          // Even split with no majority: nothing is trustworthy.
          st_nx    = ST_SAFE;
          latch_nx = 1'b1;
          cmd_nx   = DEF;
        end
      end
    end else if (a == 2) begin
      st_nx = ST_DUPLEX;
      if (in_vld) begin
        if (v1 == v2) begin
          cmd_nx = v1;
          vld_nx = 1'b1;
        end else begin
          inc    = act;
          mis_nx = act;
        end
      end
    end else begin
      st_nx    = ST_SAFE;
      latch_nx = 1'b1;
      cmd_nx   = DEF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SIMPLEX;
      latch_q   <= 1'b0;
      vote_en   <= 1'b0;
      cmd_o     <= DEF;
      cmd_vld_o <= 1'b0;
      miscmp_o  <= '0;
      fault     <= '0;
    end else begin
      state_q   <= st_nx;
      latch_q   <= latch_nx;
      vote_en   <= ve_nx;
      cmd_o     <= cmd_nx;
      cmd_vld_o <= vld_nx;
      miscmp_o  <= mis_nx;
      fault     <= clr_fault ? '0 : (fault | retire);
    end
  end

endmodule

// File: tb/tb_dnmr_voter.sv
// tb/tb_dnmr_voter.sv - self-checking bench for dnmr_voter with a behavioural model
module tb_dnmr_voter;

  localparam int N     = 3;
  localparam int CMD_W = 4;
  localparam int MAXC  = 5;
  localparam int DEFC  = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*CMD_W-1:0] rep_cmd;
  logic               in_vld;
  logic [3:0]         err_rate;
  logic [1:0]         mode;
  logic               clr_fault;
  logic [CMD_W-1:0]   cmd_o;
  logic               cmd_vld_o;
  logic [N-1:0]       fault;
  logic [N-1:0]       miscmp_o;
  logic [1:0]         state_o;

  dnmr_voter #(
    .N(N), .CMD_W(CMD_W), .DEF_CMD(DEFC), .MAX_FAULT_COUNT(MAXC), .ERR_HI(8), .ERR_LO(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rep_cmd_i (rep_cmd),
    .in_vld    (in_vld),
    .err_rate  (err_rate),
    .mode      (mode),
    .clr_fault (clr_fault),
    .cmd_o     (cmd_o),
    .cmd_vld_o (cmd_vld_o),
    .fault     (fault),
    .miscmp_o  (miscmp_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model state
  int         cnt [N];
  bit         flt [N];
  bit         latched, ve;
  int         e_cmd, e_state;
  bit         e_vld;
  logic [N-1:0] e_mis, e_fault;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // Literal expectation that pins both the DUT and the model.
  task automatic lit(input string nm, input int got, input int mdl, input int exp);
    check(nm, got, exp);
    check({nm, "_model"}, mdl, exp);
  endtask

  task automatic bump(input int i);
    if (cnt[i] < MAXC) cnt[i]++;
    if (cnt[i] >= MAXC) flt[i] = 1'b1;
    e_mis[i] = 1'b1;
  endtask

  task automatic go_safe();
    latched = 1'b1;
    e_state = 3;
    e_cmd   = DEFC;
  endtask

  task automatic model_step();
    int vals [N];
    int idx [$];
    int hist [16];
    int a, win;
    bit found;
    for (int i = 0; i < N; i++) vals[i] = int'(rep_cmd[i*CMD_W +: CMD_W]);
    e_vld = 1'b0;
    e_mis = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin cnt[i] = 0; flt[i] = 1'b0; end
      latched = 0; ve = 0; e_cmd = DEFC; e_state = 0;
    end else begin
      if (mode == 1) ve = 1;
      else if (mode == 2) ve = 0;
      else if (err_rate >= 8) ve = 1;
      else if (err_rate < 4) ve = 0;

      if (clr_fault) begin
        for (int i = 0; i < N; i++) begin cnt[i] = 0; flt[i] = 1'b0; end
        latched = 0;
        if (mode == 3) begin e_state = 3; e_cmd = DEFC; end
        else e_state = ve ? 1 : 0;
      end else if (mode == 3 || latched) begin
        e_state = 3;
        e_cmd   = DEFC;
      end else begin
        for (int i = 0; i < N; i++) if (!flt[i]) idx.push_back(i);
        a = idx.size();
        if (!ve) begin
          if (a == 0) go_safe();
          else begin
            e_state = 0;
            if (in_vld) begin e_cmd = vals[idx[0]]; e_vld = 1; end
          end
        end else if (a >= 3) begin
          e_state = 1;
          if (in_vld) begin
            for (int v = 0; v < 16; v++) hist[v] = 0;
            foreach (idx[k]) hist[vals[idx[k]]]++;
            found = 0;
            win = 0;
            for (int v = 0; v < 16; v++) if (hist[v] > a / 2) begin found = 1; win = v; end
            if (found) begin
              e_cmd = win;
              e_vld = 1;
              foreach (idx[k]) begin
                if (vals[idx[k]] != win) bump(idx[k]);
                else if (cnt[idx[k]] > 0) cnt[idx[k]]--;
              end
            end else go_safe();
          end
        end else if (a == 2) begin
          e_state = 2;
          if (in_vld) begin
            if (vals[idx[0]] == vals[idx[1]]) begin e_cmd = vals[idx[0]]; e_vld = 1; end
            else begin bump(idx[0]); bump(idx[1]); end
          end
        end else go_safe();
      end
    end
    for (int i = 0; i < N; i++) e_fault[i] = flt[i];
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    model_step();
    chk_en = 1;
  endtask

  task automatic vote(input int r2, input int r1, input int r0);
    rep_cmd = {4'(r2), 4'(r1), 4'(r0)};
    in_vld  = 1;
    cyc();
    in_vld  = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_o",     int'(cmd_o),     e_cmd);
      check("cmd_vld_o", int'(cmd_vld_o), int'(e_vld));
      check("fault",     int'(fault),     int'(e_fault));
      check("miscmp_o",  int'(miscmp_o),  int'(e_mis));
      check("state_o",   int'(state_o),   e_state);
    end
  end

  initial begin
    int errs [5];
    int sts [5];
    int base, r, sel;
    errs = '{2, 6, 9, 6, 3};
    sts  = '{0, 0, 1, 1, 0};

    rst = 1; in_vld = 0; rep_cmd = '0; err_rate = 10; mode = 0; clr_fault = 0;
    cyc();
    cyc();
    lit("rst_cmd",   int'(cmd_o),   e_cmd,        DEFC);
    lit("rst_state", int'(state_o), e_state,      0);
    lit("rst_fault", int'(fault),   int'(e_fault), 0);

    rst = 0;
    cyc();
    vote(7, 7, 7);
    lit("nmr_cmd",   int'(cmd_o),     e_cmd,       7);
    lit("nmr_vld",   int'(cmd_vld_o), int'(e_vld), 1);
    lit("nmr_state", int'(state_o),   e_state,     1);
    lit("nmr_mis",   int'(miscmp_o),  int'(e_mis), 0);

    for (int k = 0; k < 5; k++) begin
      vote(3, 7, 7);
      lit("outvote_cmd", int'(cmd_o), e_cmd, 7);
    end
    lit("retire2_fault", int'(fault), int'(e_fault), 3'b100);
    cyc();
    lit("duplex_state", int'(state_o), e_state, 2);

    for (int k = 0; k < 5; k++) begin
      vote(0, 2, 7);
      lit("dup_vld", int'(cmd_vld_o), int'(e_vld), 0);
      lit("dup_cmd", int'(cmd_o),     e_cmd,       7);
      lit("dup_mis", int'(miscmp_o),  int'(e_mis), 3'b011);
    end
    lit("all_retired", int'(fault), int'(e_fault), 3'b111);
    cyc();
    lit("safe_state", int'(state_o), e_state, 3);
    lit("safe_cmd",   int'(cmd_o),   e_cmd,   DEFC);

    clr_fault = 1; err_rate = 2;
    cyc();
    clr_fault = 0;
    lit("clr_fault", int'(fault),   int'(e_fault), 0);
    lit("clr_state", int'(state_o), e_state,       0);
    vote(1, 9, 6);
    lit("simplex_cmd", int'(cmd_o), e_cmd, 6);

    for (int k = 0; k < 5; k++) begin
      err_rate = 4'(errs[k]);
      cyc();
      lit($sformatf("hyst_%0d", k), int'(state_o), e_state, sts[k]);
    end

    mode = 3;
    vote(4, 4, 4);
    lit("sleep_cmd",   int'(cmd_o),     e_cmd,       DEFC);
    lit("sleep_vld",   int'(cmd_vld_o), int'(e_vld), 0);
    lit("sleep_state", int'(state_o),   e_state,     3);
    mode = 0;

    for (int it = 0; it < 4000; it++) begin
      rst       = ($urandom_range(0, 499) == 0);
      clr_fault = ($urandom_range(0, 59) == 0);
      sel       = $urandom_range(0, 9);
      mode      = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel == 7) ? 2'd2 : (sel == 8) ? 2'd3 : 2'd0;
      err_rate  = 4'($urandom_range(0, 15));
      in_vld    = ($urandom_range(0, 3) != 0);
      base      = $urandom_range(0, 15);
      for (int i = 0; i < N; i++) begin
        r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : base;
        rep_cmd[i*CMD_W +: CMD_W] = CMD_W'(r);
      end
      cyc();
    end
    rst = 0; clr_fault = 0; in_vld = 0; mode = 1; err_rate = 10;

    clr_fault = 1;
    cyc();
    clr_fault = 0;
    vote(6, 6, 3);
    rst = 1;
    vote(6, 6, 6);
    rst = 0;
    lit("rst_mid_cmd",   int'(cmd_o),     e_cmd,         DEFC);
    lit("rst_mid_vld",   int'(cmd_vld_o), int'(e_vld),   0);
    lit("rst_mid_mis",   int'(miscmp_o),  int'(e_mis),   0);
    lit("rst_mid_state", int'(state_o),   e_state,       0);
    lit("rst_mid_fault", int'(fault),     int'(e_fault), 0);
    cyc();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
